// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the NN datapath layer-to-layer sequencing logic.
//   seq_state_t : sequencer FSM states (IDLE, SHIFT)
//   OVF_CNT_W   : width of the dropped-vector counter
//   idx_width() : index width for an NN-element vector, never less than 1 bit
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_t;

    localparam int OVF_CNT_W = 8;

    // $clog2(1) is 0, which would give a zero-width index for a one-neuron
    // layer; clamp to a single bit so the index is always a real signal.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : nn_pkg

// File: rtl/layer_sequencer_if.sv
// -----------------------------------------------------------------------------
// layer_sequencer_if
// Bundles the producing-layer result bus and the serial next-layer bus that
// surround layer_sequencer.
//   i_valid    [NN]            per-neuron valid from the producing layer
//   i_data     [NN*dataWidth]  parallel activations, element k at k*dataWidth
//   x_valid                    serial activation valid to the next layer
//   x_out      [dataWidth]     serial activation
//   busy                       a vector is held or being replayed
//   layer_done                 one-cycle pulse alongside the last element
//   ovf                        one-cycle pulse when a vector is dropped
//   ovf_count  [OVF_CNT_W]     dropped-vector counter
// Modports:
//   slave  : the sequencer (consumes i_*, drives the rest)
//   master : the environment (drives i_*, observes the rest)
// -----------------------------------------------------------------------------
interface layer_sequencer_if
    import nn_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) ();

    logic [NN-1:0]           i_valid;
    logic [NN*dataWidth-1:0] i_data;
    logic                    x_valid;
    logic [dataWidth-1:0]    x_out;
    logic                    busy;
    logic                    layer_done;
    logic                    ovf;
    logic [OVF_CNT_W-1:0]    ovf_count;

    modport slave (
        input  i_valid,
        input  i_data,
        output x_valid,
        output x_out,
        output busy,
        output layer_done,
        output ovf,
        output ovf_count
    );

    modport master (
        output i_valid,
        output i_data,
        input  x_valid,
        input  x_out,
        input  busy,
        input  layer_done,
        input  ovf,
        input  ovf_count
    );

endinterface : layer_sequencer_if

// File: rtl/layer_seq_buf.sv
// -----------------------------------------------------------------------------
// layer_seq_buf
// NN x dataWidth vector buffer: loads the whole parallel vector in one cycle
// and presents one element selected by index.
//   clk       input   clock, rising edge
//   rst       input   asynchronous active-high reset, clears every element
//   load      input   capture i_data into the buffer on this edge
//   i_data    input   parallel vector, element k at [k*dataWidth +: dataWidth]
//   sel       input   element index
//   sel_data  output  element sel of the stored vector (combinational read)
// -----------------------------------------------------------------------------
module layer_seq_buf
    import nn_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = 16,
    parameter int SEL_W     = idx_width(NN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [NN*dataWidth-1:0] i_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [dataWidth-1:0]    sel_data
);

    logic [dataWidth-1:0] mem [NN];

    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    // NOTE: this storage is reset on purpose: the serial output is required
    // to be 0 after reset, and a held vector must not survive a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NN; k++) begin
                mem[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < NN; k++) begin
                mem[k] <= i_data[k*dataWidth +: dataWidth];
            end
        end
    end

    // When NN is not a power of two the index can encode values past the
    // last element; those read as zero instead of an undefined entry.
    assign sel_data = (int'(sel) < NN) ? mem[sel] : '0;

endmodule : layer_seq_buf

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
// Controller between two fully-connected layers. Captures one parallel result
// vector when every producing neuron is valid in the same cycle, then replays
// it one activation per cycle onto the next layer's shared x bus.
//   clk   input  clock, rising edge
//   rst   input  asynchronous active-high reset
//   bus   layer_sequencer_if.slave (see interface header for signal list)
//
// Behaviour summary:
//   - capture at edge T -> element k shown in the cycle after edge T+k,
//     layer_done with element NN-1
//   - a capture while the last element is shown is accepted seamlessly
//   - a capture earlier in a replay is dropped and reported on ovf
//   - all x_* / flag outputs come straight from flops
//
// Build option:
//   LAYER_SEQ_OVF_COUNT_EN  defined   : ovf_count is a saturating 8-bit counter
//                           undefined : ovf_count is tied to 0 (ovf still pulses)
// -----------------------------------------------------------------------------
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.slave   bus
);

    localparam int               IDX_W    = idx_width(NN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);

    seq_state_t           state, state_nxt;
    logic [IDX_W-1:0]     idx, idx_nxt;
    logic                 capture;
    logic                 load;
    logic                 drop;
    logic [dataWidth-1:0] sel_data;
    logic [dataWidth-1:0] x_out_nxt;

    logic                 x_valid_q;
    logic                 layer_done_q;
    logic                 ovf_q;
    logic [dataWidth-1:0] x_out_q;

    // Only a complete vector counts; individual neuron valids are never
    // accumulated across cycles.
    assign capture = &bus.i_valid;

    // The buffer is read at the index that will be current after this edge,
    // so the registered x_out lines up with idx.
    layer_seq_buf #(
        .NN        (NN),
        .dataWidth (dataWidth),
        .SEL_W     (IDX_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .i_data   (bus.i_data),
        .sel      (idx_nxt),
        .sel_data (sel_data)
    );

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        drop      = 1'b0;

        case (state)
            IDLE: begin
                if (capture) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (idx == LAST_IDX) begin
                    if (capture) begin
                        // Back-to-back: next vector follows with no bubble.
                        load    = 1'b1;
                        idx_nxt = '0;
                    end else begin
                        // idx is held so x_out keeps the last element.
                        state_nxt = IDLE;
                    end
                end else begin
                    idx_nxt = idx + 1'b1;
                    drop    = capture;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The freshly captured vector is not in the buffer until after this edge,
    // so its first element is taken directly from the input bus.
    always_comb begin
        x_out_nxt = x_out_q;
        if (load) begin
            x_out_nxt = bus.i_data[dataWidth-1:0];
        end else if (state_nxt == SHIFT) begin
            x_out_nxt = sel_data;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            x_valid_q    <= 1'b0;
            x_out_q      <= '0;
            layer_done_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            x_valid_q    <= (state_nxt == SHIFT);
            x_out_q      <= x_out_nxt;
            layer_done_q <= (state_nxt == SHIFT) && (idx_nxt == LAST_IDX);
            ovf_q        <= drop;
        end
    end

    assign bus.x_valid    = x_valid_q;
    assign bus.x_out      = x_out_q;
    assign bus.layer_done = layer_done_q;
    assign bus.ovf        = ovf_q;
    assign bus.busy       = (state == SHIFT);

    // ------------------------------------------------------------------
    // Dropped-vector counter
    // ------------------------------------------------------------------
`ifdef LAYER_SEQ_OVF_COUNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q;

    // Saturates at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= '0;
        end else if (drop && (ovf_cnt_q != '1)) begin
            ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    assign bus.ovf_count = ovf_cnt_q;
`else
    assign bus.ovf_count = '0;
`endif

endmodule : layer_sequencer

// File: doc/layer_sequencer.md
# layer_sequencer

Controller between two fully-connected layers of the NN datapath. Captures one parallel result vector, NN neurons × dataWidth, from a layer when every neuron reports valid. Replays the vector serially, one activation per cycle, onto the next layer's shared `x_in`/`x_valid` bus, which feeds every neuron of that layer. Sequences layer-to-layer hand-off with a defined overflow policy and a done pulse for the top-level controller.

## Interface
- `NN`, 30, neurons in the producing layer (elements per vector), ≥1
- `dataWidth`, 16, bits per activation
- `clk`  input  1  clock, all logic on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `i_valid`  input  NN  per-neuron valid from producing layer
- `i_data`  input  NN*dataWidth  parallel activations; element k at `[k*dataWidth +: dataWidth]`
- `x_valid`  output  1  serial activation valid to next layer
- `x_out`  output  dataWidth  serial activation
- `busy`  output  1  high while a vector is held or being replayed
- `layer_done`  output  1  one-cycle pulse with the last element
- `ovf`  output  1  one-cycle pulse when a vector is dropped
- `ovf_count`  output  8  dropped-vector counter (see Configuration)

## Operation
- States: IDLE, SHIFT.
- Capture condition: `&i_valid` sampled high on a clock edge. Partial valid is ignored; the block does not accumulate individual neuron valids.
- IDLE and capture → copy `i_data` into the internal buffer, clear index `idx` to 0, go to SHIFT.
- SHIFT:
  - Each cycle drive `x_out` = buffer element `idx`, with `x_valid`=1.
  - Increment `idx` by 1 each cycle.
  - When `idx`=NN-1, assert `layer_done` with that element.
  - Next state is IDLE, unless capture occurs in that same cycle (see back-to-back).
- Back-to-back: capture in the cycle `idx`=NN-1 is accepted.
  - The buffer is reloaded and `idx` returns to 0.
  - State stays SHIFT, so there is no bubble between vectors.
- Overflow: capture in SHIFT with `idx`<NN-1 is dropped.
  - Buffer and `idx` are unaffected.
  - `ovf` pulses for one cycle and `ovf_count` increments.
- `busy` = (state==SHIFT).
- `idx` width is clog2(NN), with a minimum of 1. NN=1 degenerates to a single cycle with `x_valid` and `layer_done` both high.
- Outputs are registered, with no combinational path from `i_*` to `x_*`.

## Timing
- Reset values: state IDLE; `idx`=0; `x_valid`=0; `x_out`=0; `busy`=0; `layer_done`=0; `ovf`=0; `ovf_count`=0; buffer=0.
- Latency: capture at edge T gives the first `x_valid` in the cycle after T. Element k appears at T+1+k, and `layer_done` at T+NN.
- `x_valid` stays high for exactly NN consecutive cycles per accepted vector.
- `x_out` holds its last value when `x_valid`=0; consumers must qualify with `x_valid`.
- Reset mid-SHIFT: outputs return to reset values immediately (asynchronous). The partial vector is discarded and no `layer_done` is issued.
- `ovf_count` saturates at 255 and does not wrap.
- No backpressure: downstream neurons accept one element per cycle unconditionally.

## Configuration
- Macro: `LAYER_SEQ_OVF_COUNT_EN`.
- Defined:
  - `ovf_count` is implemented as the saturating 8-bit counter described above.
  - `ovf` pulses as specified.
- Undefined:
  - `ovf_count` is tied to 0 and has no counter flops.
  - `ovf` still pulses.
  - Drop behaviour is unchanged.

## Structure
- Shared package `nn_pkg`:
  - state enum `seq_state_t` (IDLE, SHIFT)
  - constant `OVF_CNT_W`=8
  - clog2-style width helper used for `idx`
- One sub-module, `layer_seq_buf`:
  - NN×dataWidth load-and-select buffer
  - inputs: `load`, `i_data`, `sel`
  - output: `sel_data`
- The top module holds the FSM, `idx`, flags and counter.

## Test plan
- Reset then idle, NN=4, dataWidth=16: no `i_valid` for 20 cycles → `x_valid`=0, `busy`=0, all outputs 0.
- Single vector: `i_valid`=4'b1111, `i_data`={16'h0004,16'h0003,16'h0002,16'h0001} at edge T → `x_out` 1,2,3,4 at T+1..T+4, `layer_done` at T+4, then `busy`=0 at T+5.
- Partial valid: `i_valid`=4'b0111 held for 10 cycles → no capture, `x_valid` stays 0.
- Back-to-back: second vector {8,7,6,5} presented at T+4 → `x_out` 1,2,3,4,5,6,7,8 contiguous with no bubble, and two `layer_done` pulses at T+4 and T+8.
- Overflow: second vector at T+2 → dropped; `ovf` pulse at the next cycle; `ovf_count`=1 (0 without macro); stream still 1,2,3,4.
- Async reset mid-stream: assert `rst` at T+2.5 → `x_valid`, `busy`, `idx` go to 0 without a clock edge; after release, a fresh vector streams correctly.
